// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// signed/unsigned operands, divide-by-zero shortcut and annulment.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  Rst_n,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2*DATA_W:0]      dividend_reg, dividend_next;
    logic [DATA_W-1:0]      divisor_reg, divisor_next;
    logic                   qneg_reg, qneg_next;
    logic                   rneg_reg, rneg_next;
    logic [2*DATA_W-1:0]    result_reg, result_next;
    logic                   ready_reg, ready_next;

    logic [DATA_W-1:0]      op1_abs, op2_abs;
    logic [DATA_W:0]        diff;
    logic [DATA_W-1:0]      quot_fix, rem_fix;

    // Magnitudes are taken only for signed requests; 0x80000000 stays as-is
    // and is treated as an unsigned 2^31 by the iteration.
    assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

    assign diff = {1'b0, dividend_reg[2*DATA_W-1:DATA_W]} - {1'b0, divisor_reg};

    assign quot_fix = qneg_reg ? (~dividend_reg[DATA_W-1:0] + DATA_W'(1))
                               : dividend_reg[DATA_W-1:0];
    assign rem_fix  = rneg_reg ? (~dividend_reg[2*DATA_W:DATA_W+1] + DATA_W'(1))
                               : dividend_reg[2*DATA_W:DATA_W+1];

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        qneg_next     = qneg_reg;
        rneg_next     = rneg_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        case (state_reg)
            FREE: begin
                result_next = '0;
                ready_next  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = BYZERO;
                    end else begin
                        state_next    = ON;
                        cnt_next      = '0;
                        dividend_next = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                        divisor_next  = op2_abs;
                        qneg_next     = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        rneg_next     = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
            end

            BYZERO: begin
                result_next = '0;
                if (annul_i) begin
                    state_next = FREE;
                    ready_next = 1'b0;
                end else begin
                    state_next = END;
                    ready_next = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_next  = FREE;
                    cnt_next    = '0;
                    result_next = '0;
                    ready_next  = 1'b0;
                end else if (cnt_reg != CNT_W'(DATA_W)) begin
                    // Restore by simply not committing a negative trial subtraction.
                    if (diff[DATA_W])
                        dividend_next = {dividend_reg[2*DATA_W-1:0], 1'b0};
                    else
                        dividend_next = {diff[DATA_W-1:0], dividend_reg[DATA_W-1:0], 1'b1};
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    result_next = {rem_fix, quot_fix};
                    ready_next  = 1'b1;
                    state_next  = END;
                    cnt_next    = '0;
                end
            end

            END: begin
                if (annul_i || !start_i) begin
                    state_next  = FREE;
                    result_next = '0;
                    ready_next  = 1'b0;
                end
            end

            default: begin
                state_next = FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst_n) begin
            state_reg    <= FREE;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            qneg_reg     <= 1'b0;
            rneg_reg     <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            qneg_reg     <= qneg_next;
            rneg_reg     <= rneg_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: scoreboard of expected
// {remainder, quotient} results checked against the response on ready.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .Rst_n        (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division in 64-bit arithmetic; x/0 answers 0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request: check latency, result, hold stability, and release.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int hold, input string name);
        logic [63:0] exp_res;
        logic [63:0] got;
        int lat;
        int exp_lat;
        bit seen;
        exp_q.push_back(model(a, b, sgn));
        exp_lat    = (b == 32'h0) ? 2 : 34;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            tick();
            lat++;
            if (ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = 1'($urandom);
            end
        end
        exp_res = exp_q.pop_front();
        got     = result;
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        if (seen) begin
            n_checks++;
            if (got !== exp_res) begin
                n_fail++;
                $display("FAIL %s result: got %h, expected %h", name, got, exp_res);
            end
            $display("txn %s: %h / %h signed=%0d -> %h (expected %h) latency %0d",
                     name, a, b, sgn, got, exp_res, lat);
            for (int i = 0; i < hold; i++) begin
                tick();
                n_checks++;
                if (ready !== 1'b1 || result !== got) begin
                    n_fail++;
                    $display("FAIL %s hold cycle %0d: ready=%b result=%h, expected ready=1 result=%h",
                             name, i, ready, result, got);
                end
            end
        end
        start = 1'b0;
        tick();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL %s release: ready=%b result=%h, expected ready=0 result=0",
                     name, ready, result);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; annul = 1'b0;
        opdata1 = 32'd100; opdata2 = 32'd0; signed_div = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b result=%h, expected 0/0", ready, result);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%b result=%h, expected 0/0", ready, result);
        end
        $display("txn reset: ready=%b result=%h", ready, result);
    endtask

    task automatic test_unsigned();
        run_div(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 0, "u_ffffffff_div_16");
        run_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, "u_max_div_2p31");
        run_div(32'd5,         32'd7,         1'b0, 0, "u_small_by_large");
        run_div(32'h0,         32'd5,         1'b0, 0, "u_zero_dividend");
        run_div(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, "u_equal");
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'h2,         1'b1, 0, "s_m7_div_2");
        run_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 0, "s_7_div_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_overflow");
        run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0, "s_m7_div_m2");
        run_div(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s_min_div_min");
        run_div(32'hFFFF_FFF9, 32'h2,         1'b0, 0, "u_same_bits_as_m7");
    endtask

    task automatic test_byzero();
        run_div(32'h0000_1234, 32'h0, 1'b0, 0, "byzero_u");
        run_div(32'hFFFF_FFFF, 32'h0, 1'b1, 2, "byzero_s_hold");
    endtask

    task automatic test_annul();
        bit bad;
        opdata1 = 32'h1234_5678; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (ready !== 1'b0) bad = 1'b1;
        end
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        repeat (3) begin
            tick();
            if (ready !== 1'b0 || result !== 64'h0) bad = 1'b1;
        end
        n_checks++;
        if (bad || ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL annul_mid_op: ready=%b result=%h, expected ready=0 result=0", ready, result);
        end
        $display("txn annul at cnt=10: ready=%b result=%h", ready, result);
        run_div(32'd100, 32'd7, 1'b0, 0, "after_annul_100_div_7");

        opdata1 = 32'h1234; opdata2 = 32'h0; start = 1'b1;
        tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        tick();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL annul_byzero: ready=%b result=%h, expected ready=0 result=0", ready, result);
        end
        $display("txn annul in BYZERO: ready=%b", ready);

        opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1;
        bad = 1'b1;
        for (int i = 0; i < 60 && bad; i++) begin
            tick();
            if (ready === 1'b1) bad = 1'b0;
        end
        annul = 1'b1;
        tick();
        annul = 1'b0;
        start = 1'b0;
        n_checks++;
        if (bad || ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL annul_end: timeout=%b ready=%b result=%h, expected ready=0 result=0",
                     bad, ready, result);
        end
        $display("txn annul in END: ready=%b result=%h", ready, result);
        tick();
    endtask

    task automatic test_reset_mid();
        bit bad;
        opdata1 = 32'h7FFF_FFFF; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
        repeat (21) tick();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op: ready=%b result=%h, expected 0/0", ready, result);
        end
        $display("txn reset at cnt=20: ready=%b result=%h", ready, result);
        run_div(32'd9, 32'd3, 1'b0, 0, "after_reset_9_div_3");

        opdata1 = 32'd1000; opdata2 = 32'd10; start = 1'b1;
        bad = 1'b1;
        for (int i = 0; i < 60 && bad; i++) begin
            tick();
            if (ready === 1'b1) bad = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        n_checks++;
        if (bad || ready !== 1'b0 || result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_in_end: timeout=%b ready=%b result=%h, expected 0/0",
                     bad, ready, result);
        end
        $display("txn reset in END: ready=%b result=%h", ready, result);
        tick();
    endtask

    task automatic test_hold();
        run_div(32'd123456789, 32'd1000, 1'b0, 5, "hold_5_cycles");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 12; i++) begin
            s = 1'($urandom);
            a = $urandom;
            if (s) b = $urandom >> $urandom_range(0, 31);
            else   b = $urandom >> $urandom_range(1, 31);
            if (b == 32'h0) b = 32'd1;
            run_div(a, b, s, 0, $sformatf("b2b_%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_byzero();
        test_annul();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle restoring divider that services DIV/DIVU requests issued by the EX stage. It is the responder end of the EX divide handshake.
- While the divider is busy, EX holds start_i high and stalls the pipeline. On completion it returns {remainder, quotient}; EX forwards these as HI/LO toward ex_mem and the HI/LO register.
- Produces one quotient bit per cycle, supports signed and unsigned operands, and handles divide-by-zero and annulment.

Parameters:
- DATA_W, 32, operand width. Result width is 2*DATA_W. Iteration count equals DATA_W.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- Rst_n  input  1  synchronous, active-high reset (asserted level = `RstEnable = 1).
- signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU.
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request. Held high by EX until ready_o is seen.
- annul_i  input  1  abort the current or pending operation (flush).
- result_o  output  64  {remainder[31:0], quotient[31:0]}. Valid only while ready_o = 1.
- ready_o  output  1  result valid.

Behaviour:
- Reset (Rst_n = 1 at an edge): state goes to FREE, cnt = 0, result_o = 0, ready_o = 0, internal registers = 0. Reset overrides all other inputs, including mid-operation.

Internal state:
- state is one of FREE, BYZERO, ON, END.
- cnt is 6 bits.
- dividend is 65 bits; divisor is 32 bits.
- Latched sign flags: qneg, rneg.

FREE:
- start_i = 1 and annul_i = 0, opdata2_i == 0: go to BYZERO.
- start_i = 1 and annul_i = 0, opdata2_i != 0: go to ON, with:
  - cnt = 0
  - dividend = {32'b0, |op1|, 1'b0}
  - divisor = |op2|
  - qneg = signed_div_i & (op1[31] ^ op2[31])
  - rneg = signed_div_i & op1[31]
- |x| is the two's-complement negate only when signed_div_i = 1 and x[31] = 1; otherwise x unchanged. |0x80000000| = 0x80000000 as unsigned.
- Otherwise stay in FREE with ready_o = 0 and result_o = 0.

BYZERO:
- Next edge goes to END with result_o = 0 and ready_o = 1, unless annul_i = 1, in which case go to FREE.

ON (annul_i = 0, cnt < 32):
- diff = {1'b0, dividend[63:32]} - {1'b0, divisor}.
- If diff[32] = 1: dividend <= {dividend[63:0], 1'b0}.
- Else: dividend <= {diff[31:0], dividend[31:0], 1'b1}.
- cnt <= cnt + 1.

ON (annul_i = 0, cnt == 32):
- quotient q = dividend[31:0], negated if qneg.
- remainder r = dividend[64:33], negated if rneg.
- result_o <= {r, q}, ready_o <= 1, state <= END, cnt <= 0.

ON (annul_i = 1): go to FREE, result_o = 0, ready_o = 0. The partial result is discarded.

END:
- ready_o and result_o hold while start_i = 1.
- When start_i = 0 is sampled: go to FREE, ready_o <= 0, result_o <= 0.
- annul_i in END also returns to FREE.

Latency (start_i first sampled at edge E0):
- Normal divide: ready_o = 1 after edge E0 + 33. That is 1 load cycle, 32 iterations, and the sign fix merged with the final iteration check at cnt == 32; 34 cycles total from request to ready.
- Divide-by-zero: ready_o = 1 after edge E0 + 1.

Operand sign flags are latched at start, so operands need not stay stable after the load edge.

Arithmetic results:
- Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the defined overflow result.
- A new request is accepted only from FREE, so back-to-back divides need at least one cycle with start_i = 0.

Test Plan:
- Unsigned: op1 = 0xFFFFFFFF, op2 = 0x10, signed = 0 -> after 34 cycles ready_o = 1, result_o = {0x0000000F, 0x0FFFFFFF}.
- Signed: -7 / 2 (0xFFFFFFF9, 0x2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / -2 -> {0x00000001, 0xFFFFFFFD}. Also -2^31 / -1 -> {0x00000000, 0x80000000}.
- Divide-by-zero: op1 = 0x1234, op2 = 0, start_i = 1 -> ready_o = 1 two edges after request, result_o = 0. Then drop start_i -> ready_o = 0 next edge and state returns to FREE.
- Annul: pulse annul_i at iteration cnt = 10 -> ready_o stays 0, result_o = 0, and the block is back in FREE. A new request 100 / 7 then returns {2, 14} after 34 cycles.
- Reset mid-operation: assert Rst_n at cnt = 20 -> all outputs 0 next edge. After deassert, 9 / 3 -> {0, 3}.
- Hold: keep start_i = 1 for 5 cycles after ready_o -> result_o stable each cycle; release -> ready_o = 0 and result_o = 0 on the next edge.
